// File: rtl/pgm_video_pkg.sv
// Shared PGM video-path types and widths used by the graphics fetchers and the DDRAM arbiter.
package pgm_video_pkg;

    localparam int unsigned GFX_ADDR_W = 29;
    localparam int unsigned GFX_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_SPR  = 1'b0,
        OWN_TILE = 1'b1
    } owner_t;

endpackage

// File: rtl/pgm_gfx_ddram_arbiter.sv
// Shares the DDRAM graphics read port between the sprite and tile fetchers:
// sprite priority with a starvation guard, one outstanding read at a time.
module pgm_gfx_ddram_arbiter
    import pgm_video_pkg::*;
#(
    parameter int unsigned ADDR_W       = GFX_ADDR_W,
    parameter int unsigned DATA_W       = GFX_DATA_W,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic              spr_ack,
    output logic              spr_valid,

    input  logic              tile_req,
    input  logic [ADDR_W-1:0] tile_addr,
    output logic              tile_ack,
    output logic              tile_valid,

    output logic [DATA_W-1:0] rdata,
    output logic              rerr,

    output logic              ddram_rd,
    output logic [ADDR_W-1:0] ddram_addr,
    input  logic [DATA_W-1:0] ddram_dout,
    input  logic              ddram_busy,
    input  logic              ddram_dout_ready,

    output logic              arb_busy,
    output logic              arb_owner
);

    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TO_W = 8;

    arb_state_t        state;
    owner_t            owner_q;
    owner_t            grant_c;
    logic [SC_W-1:0]   starve_cnt;
    logic [TO_W-1:0]   to_cnt;

    // Sprite wins unless it is idle or the tile side has waited out its quota.
    function automatic owner_t pick_owner(input logic s_req, input logic t_req,
                                          input logic [SC_W-1:0] cnt);
        if (t_req && (!s_req || cnt == SC_W'(STARVE_LIMIT))) begin
            return OWN_TILE;
        end
        return OWN_SPR;
    endfunction

    always_comb begin
        grant_c = pick_owner(spr_req, tile_req, starve_cnt);
    end

    assign arb_owner = (owner_q == OWN_TILE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner_q    <= OWN_SPR;
            starve_cnt <= '0;
            to_cnt     <= '0;
            spr_ack    <= 1'b0;
            spr_valid  <= 1'b0;
            tile_ack   <= 1'b0;
            tile_valid <= 1'b0;
            rdata      <= '0;
            rerr       <= 1'b0;
            ddram_rd   <= 1'b0;
            ddram_addr <= '0;
            arb_busy   <= 1'b0;
        end else begin
            spr_ack    <= 1'b0;
            spr_valid  <= 1'b0;
            tile_ack   <= 1'b0;
            tile_valid <= 1'b0;
            rerr       <= 1'b0;

            case (state)
                IDLE: begin
                    if (!tile_req) begin
                        starve_cnt <= '0;
                    end
                    if (spr_req || tile_req) begin
                        owner_q    <= grant_c;
                        ddram_addr <= (grant_c == OWN_TILE) ? tile_addr : spr_addr;
                        ddram_rd   <= 1'b1;
                        arb_busy   <= 1'b1;
                        state      <= ISSUE;
                        // Count sprite wins only while a tile request is being passed over.
                        if (grant_c == OWN_TILE) begin
                            starve_cnt <= '0;
                        end else if (tile_req && starve_cnt != SC_W'(STARVE_LIMIT)) begin
                            starve_cnt <= starve_cnt + SC_W'(1);
                        end
                    end
                end

                ISSUE: begin
                    if (!ddram_busy) begin
                        ddram_rd <= 1'b0;
                        to_cnt   <= '0;
                        state    <= WAIT;
                        if (owner_q == OWN_TILE) begin
                            tile_ack <= 1'b1;
                        end else begin
                            spr_ack <= 1'b1;
                        end
                    end
                end

                WAIT: begin
                    if (ddram_dout_ready || to_cnt == TO_W'(TIMEOUT - 1)) begin
                        rdata    <= ddram_dout_ready ? ddram_dout : '0;
                        rerr     <= !ddram_dout_ready;
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                        if (owner_q == OWN_TILE) begin
                            tile_valid <= 1'b1;
                        end else begin
                            spr_valid <= 1'b1;
                        end
                    end
                    to_cnt <= to_cnt + TO_W'(1);
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pgm_gfx_ddram_arbiter.sv
// Randomized scoreboard bench for pgm_gfx_ddram_arbiter with a transaction-level reference model.
module tb_pgm_gfx_ddram_arbiter;

    localparam int AW    = 29;
    localparam int DW    = 64;
    localparam int LIMIT = 4;
    localparam int TMO   = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          spr_req = 1'b0, tile_req = 1'b0;
    logic [AW-1:0] spr_addr = '0, tile_addr = '0;
    logic          spr_ack, spr_valid, tile_ack, tile_valid;
    logic [DW-1:0] rdata;
    logic          rerr;
    logic          ddram_rd;
    logic [AW-1:0] ddram_addr;
    logic [DW-1:0] ddram_dout = '0;
    logic          ddram_busy = 1'b0, ddram_dout_ready = 1'b0;
    logic          arb_busy, arb_owner;

    pgm_gfx_ddram_arbiter dut (
        .clk(clk), .reset(reset),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_valid(spr_valid),
        .tile_req(tile_req), .tile_addr(tile_addr), .tile_ack(tile_ack), .tile_valid(tile_valid),
        .rdata(rdata), .rerr(rerr),
        .ddram_rd(ddram_rd), .ddram_addr(ddram_addr), .ddram_dout(ddram_dout),
        .ddram_busy(ddram_busy), .ddram_dout_ready(ddram_dout_ready),
        .arb_busy(arb_busy), .arb_owner(arb_owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          is_valid;
        bit          owner;
        logic [63:0] data;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle, any ack/valid pulse must match the scoreboard head scheduled for it.
    exp_t       mon_e;
    logic [3:0] mon_got, mon_want;
    always begin
        @(posedge clk);
        #2;
        mon_got = {spr_ack, spr_valid, tile_ack, tile_valid};
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e    = sb.pop_front();
            mon_want = mon_e.is_valid ? (mon_e.owner ? 4'b0001 : 4'b0100)
                                      : (mon_e.owner ? 4'b0010 : 4'b1000);
            chk(mon_got == mon_want, mon_e.is_valid ? "valid_pulse" : "ack_pulse",
                64'(mon_got), 64'(mon_want));
            if (mon_e.is_valid) begin
                chk(rdata == mon_e.data, "rdata", rdata, mon_e.data);
                chk(rerr == mon_e.err, "rerr", 64'(rerr), 64'(mon_e.err));
                chk(arb_busy == 1'b0, "busy_after_valid", 64'(arb_busy), 64'd0);
            end
        end else begin
            chk(mon_got == 4'b0000, "no_pulse", 64'(mon_got), 64'd0);
        end
    end

    // Reference model state (transaction level).
    bit          m_idle = 1'b1, m_issue = 1'b0, m_wait = 1'b0;
    int          m_starve = 0;
    bit          m_tile_low = 1'b0;
    bit          m_owner = 1'b0;
    logic [AW-1:0] m_addr = '0;
    int          m_valid_cyc = -1, m_ready_cyc = -1, m_ack_cyc = -1;
    logic [63:0] m_data = '0;
    bit          prev_rd = 1'b0;
    bit          s_pend = 0, t_pend = 0, s_gnt = 0, t_gnt = 0;
    int          p_spr = 0, p_tile = 0;
    bit          drop_en = 0, force_to = 0;
    int          to_budget = 0, n_to = 0;
    bit          grants[$];

    task automatic step();
        int c, st, lat;
        bit rise, exp_rise, own, to;
        c    = cyc;
        rise = ddram_rd && !prev_rd;
        if (m_idle) begin
            exp_rise = spr_req || tile_req;
            chk(rise == exp_rise, "grant_timing", 64'(rise), 64'(exp_rise));
            if (exp_rise && rise) begin
                st  = m_tile_low ? 0 : m_starve;
                own = tile_req && (!spr_req || st == LIMIT);
                m_starve   = own ? 0 : (tile_req ? ((st + 1 > LIMIT) ? LIMIT : st + 1) : 0);
                m_tile_low = 1'b0;
                m_addr     = own ? tile_addr : spr_addr;
                chk(arb_owner == own, "grant_owner", 64'(arb_owner), 64'(own));
                chk(ddram_addr == m_addr, "grant_addr", 64'(ddram_addr), 64'(m_addr));
                chk(arb_busy == 1'b1, "busy_on_grant", 64'(arb_busy), 64'd1);
                grants.push_back(arb_owner);
                m_owner = own;
                m_idle  = 1'b0;
                m_issue = 1'b1;
                if (own) t_gnt = 1'b1; else s_gnt = 1'b1;
            end
        end
        if (m_wait && c == m_valid_cyc) begin
            m_wait = 1'b0;
            m_idle = 1'b1;
        end
        if (m_issue)
            chk(ddram_rd && ddram_addr == m_addr, "issue_hold", 64'({ddram_rd, ddram_addr}), 64'({1'b1, m_addr}));
        else
            chk(!ddram_rd, "rd_low", 64'(ddram_rd), 64'd0);
        prev_rd = ddram_rd;

        // DDRAM data side: real response on schedule, spurious strobes outside WAIT.
        if (m_wait) begin
            ddram_dout_ready = (c == m_ready_cyc);
            ddram_dout       = (c == m_ready_cyc) ? m_data : {$urandom, $urandom};
        end else begin
            ddram_dout_ready = ($urandom % 4 == 0);
            ddram_dout       = {$urandom, $urandom};
        end

        // DDRAM command side: random busy, acceptance schedules ack and valid.
        ddram_busy = m_issue ? ($urandom % 3 == 0) : 1'($urandom % 2);
        if (m_issue && !ddram_busy) begin
            m_issue   = 1'b0;
            m_wait    = 1'b1;
            m_ack_cyc = c + 1;
            sb.push_back('{c + 1, 1'b0, m_owner, 64'd0, 1'b0});
            to = force_to || (to_budget > 0 && $urandom % 48 == 0);
            if (to) begin
                n_to++;
                if (!force_to) to_budget--;
                force_to    = 1'b0;
                m_ready_cyc = -1;
                m_valid_cyc = c + 1 + TMO;
                m_data      = 64'd0;
            end else begin
                lat         = int'($urandom % 6);
                m_ready_cyc = c + 1 + lat;
                m_valid_cyc = c + 2 + lat;
                m_data      = {$urandom, $urandom};
            end
            sb.push_back('{m_valid_cyc, 1'b1, m_owner, m_data, to});
        end

        // Requesters: level request held until ack, optionally dropped after grant.
        if (s_gnt) begin
            if (c == m_ack_cyc && !m_owner) begin s_gnt = 0; s_pend = 0; end
            else if (drop_en && $urandom % 8 == 0) spr_req = 1'b0;
        end
        if (!s_gnt && !s_pend) begin
            spr_req = 1'b0;
            if ($urandom_range(99) < p_spr) begin
                s_pend = 1; spr_req = 1'b1; spr_addr = AW'($urandom);
            end
        end
        if (t_gnt) begin
            if (c == m_ack_cyc && m_owner) begin t_gnt = 0; t_pend = 0; end
            else if (drop_en && $urandom % 8 == 0) tile_req = 1'b0;
        end
        if (!t_gnt && !t_pend) begin
            tile_req = 1'b0;
            if ($urandom_range(99) < p_tile) begin
                t_pend = 1; tile_req = 1'b1; tile_addr = AW'($urandom);
            end
        end
        if (m_idle && !tile_req) m_tile_low = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            @(negedge clk);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({spr_ack, spr_valid, tile_ack, tile_valid, rerr, ddram_rd, arb_busy, arb_owner} == 8'd0,
            name, 64'({spr_ack, spr_valid, tile_ack, tile_valid, rerr, ddram_rd, arb_busy, arb_owner}), 64'd0);
        chk(rdata == '0, {name, "_rdata"}, rdata, 64'd0);
        chk(ddram_addr == '0, {name, "_addr"}, 64'(ddram_addr), 64'd0);
    endtask

    bit exp_own;

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        reset = 1'b0;

        // Both sides requesting continuously: starvation guard pattern.
        p_spr = 100; p_tile = 100; drop_en = 0;
        for (int i = 0; i < 400 && grants.size() < 10; i++) begin
            step();
            @(negedge clk);
        end
        chk(grants.size() >= 10, "grant_count", 64'(grants.size()), 64'd10);
        for (int i = 0; i < 10 && i < grants.size(); i++) begin
            exp_own = ((i % 5) == 4);
            chk(grants[i] == exp_own, "grant_order", 64'(grants[i]), 64'(exp_own));
        end

        // Random traffic with drops, busy stalls and occasional timeouts.
        p_spr = 40; p_tile = 35; drop_en = 1; to_budget = 2;
        run(2500);

        // Guaranteed timeout.
        p_spr = 50; p_tile = 50; force_to = 1;
        run(600);
        chk(n_to >= 1, "timeout_seen", 64'(n_to), 64'd1);

        // Asynchronous reset while waiting on a read that will never return.
        force_to = 1;
        for (int i = 0; i < 800 && !(m_wait && m_ready_cyc < 0 && cyc >= m_ack_cyc + 2); i++) begin
            step();
            @(negedge clk);
        end
        chk(m_wait && m_ready_cyc < 0, "reach_wait", 64'(m_wait), 64'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        sb.delete();
        m_idle = 1; m_issue = 0; m_wait = 0; m_starve = 0; m_tile_low = 0;
        m_ack_cyc = -1; m_valid_cyc = -1; m_ready_cyc = -1; prev_rd = 0;
        s_pend = 0; t_pend = 0; s_gnt = 0; t_gnt = 0; force_to = 0;
        p_spr = 0; p_tile = 0;
        spr_req = 1'b0; tile_req = 1'b0; ddram_busy = 1'b0; ddram_dout_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ddram_dout_ready = 1'b1;
        ddram_dout = 64'hDEADBEEF_01234567;
        @(negedge clk);
        run(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
